// File: rtl/f_pc_unit.sv
// f_pc_unit -- fetch-stage program-counter unit for the pipelined MIPS core.
//
// Holds the fetch PC and selects its successor from the sequential, branch,
// jump, jump-register, exception-entry and eret sources. A small circular
// return-address stack shadows jal/jalr and jr $31. It only reports
// mispredictions and never steers the PC.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   stall           freeze the PC and the RAS (hazard unit)
//   req             exception/interrupt request from CP0; beats stall
//   eret, EPC       return from exception to EPC + ERET_OFS
//   nPcSel          000 seq, 001 branch taken, 010 j/jal, 011 jr/jalr
//   imm             instr_index, or imm16 in [15:0] for branches
//   PC_D            PC of the D-stage instruction
//   ra              forwarded rs value, used as the jr/jalr target
//   is_call/is_ret  D-stage instruction is jal/jalr, or jr $31
//   PC_F            current fetch PC
//   adel_F          PC_F misaligned or outside [IM_LO, IM_HI]
//   ras_miss        registered one-cycle pulse on a wrong or empty RAS pop
//   ras_cnt         number of valid RAS entries
module f_pc_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter logic [31:0] ERET_OFS  = 32'd0,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         req,
  input  logic                         eret,
  input  logic [31:0]                  EPC,
  input  logic [2:0]                   nPcSel,
  input  logic [25:0]                  imm,
  input  logic [31:0]                  PC_D,
  input  logic [31:0]                  ra,
  input  logic                         is_call,
  input  logic                         is_ret,
  output logic [31:0]                  PC_F,
  output logic                         adel_F,
  output logic                         ras_miss,
  output logic [$clog2(RAS_DEPTH):0]   ras_cnt
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = RAS_DEPTH[PW:0];

  logic [31:0]   pcF_q, pcF_d;
  logic [PW-1:0] rasPtr_q, rasPtr_d;
  logic [PW:0]   rasCnt_q, rasCnt_d;
  logic          rasMiss_q, rasMiss_d;
  logic [31:0]   rasMem_q [RAS_DEPTH];

  logic          rasActive;
  logic          doPush, doPop, doBoth;
  logic [PW-1:0] topIdx;
  logic [31:0]   topEntry;
  logic          memWe;
  logic [PW-1:0] memIdx;
  logic [31:0]   branchTarget, jumpTarget, retAddr;

  // Branch offset is the sign-extended imm16 scaled to words; all adds wrap mod 2^32.
  assign branchTarget = PC_D + 32'd4 + {{14{imm[15]}}, imm[15:0], 2'b00};
  assign jumpTarget   = {PC_D[31:28], imm, 2'b00};
  assign retAddr      = PC_D + 32'd8;

  // Next-PC priority: exception entry, then stall, then eret, then nPcSel.
  always_comb begin
    pcF_d = pcF_q + 32'd4;
    if (req) begin
      pcF_d = EXC_VEC;
    end else if (stall) begin
      pcF_d = pcF_q;
    end else if (eret) begin
      pcF_d = EPC + ERET_OFS;
    end else begin
      case (nPcSel)
        3'b001:  pcF_d = branchTarget;
        3'b010:  pcF_d = jumpTarget;
        3'b011:  pcF_d = ra;
        default: pcF_d = pcF_q + 32'd4;
      endcase
    end
  end

  // The RAS only moves on cycles that actually advance the pipeline.
  assign rasActive = !req && !stall;
  assign doPush    = rasActive && is_call && !is_ret;
  assign doPop     = rasActive && is_ret && !is_call;
  assign doBoth    = rasActive && is_call && is_ret;

  // The most recent entry sits just below the write pointer.
  assign topIdx   = rasPtr_q - 1'b1;
  assign topEntry = rasMem_q[topIdx];

  always_comb begin
    rasPtr_d  = rasPtr_q;
    rasCnt_d  = rasCnt_q;
    rasMiss_d = 1'b0;
    memWe     = 1'b0;
    memIdx    = rasPtr_q;
    if (doPush) begin
      // Pointer wraps naturally because the depth is a power of two, so an
      // overflowing push overwrites the oldest entry.
      memWe    = 1'b1;
      memIdx   = rasPtr_q;
      rasPtr_d = rasPtr_q + 1'b1;
      if (rasCnt_q != DEPTH_CNT) begin
        rasCnt_d = rasCnt_q + 1'b1;
      end
    end else if (doPop) begin
      if (rasCnt_q == '0) begin
        rasMiss_d = 1'b1;
      end else begin
        rasPtr_d  = topIdx;
        rasCnt_d  = rasCnt_q - 1'b1;
        rasMiss_d = (topEntry != ra);
      end
    end else if (doBoth) begin
      // Push and pop cancel: replace the top entry in place.
      memWe  = 1'b1;
      memIdx = topIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcF_q     <= PC_RESET;
      rasPtr_q  <= '0;
      rasCnt_q  <= '0;
      rasMiss_q <= 1'b0;
    end else begin
      pcF_q     <= pcF_d;
      rasPtr_q  <= rasPtr_d;
      rasCnt_q  <= rasCnt_d;
      rasMiss_q <= rasMiss_d;
    end
  end

  // Stack storage carries no reset; stale entries are hidden by a zero count.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      rasMem_q[memIdx] <= retAddr;
    end
  end

  assign PC_F     = pcF_q;
  assign adel_F   = (pcF_q[1:0] != 2'b00) || (pcF_q < IM_LO) || (pcF_q > IM_HI);
  assign ras_miss = rasMiss_q;
  assign ras_cnt  = rasCnt_q;

endmodule
